display_seq_monitor: RTL and testbench

DISPLAY_SEQ_MONITOR -- requirements
Module: display_seq_monitor

---
 rtl/display_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 29 ++
 rtl/display_seq_monitor.sv | 119 +++++++++++
 tb/tb_display_seq_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment sequence monitor.
// Segment codes are active-low with bit7 = dp (unlit = 1).
package display_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        RELOCK = 2'd2
    } state_t;

    // Index i holds the code that displays hex digit i.
    localparam logic [15:0][7:0] SEG_CODE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [3:0] wrap_inc(
        input logic [3:0] d,
        input logic [4:0] m
    );
        return ({1'b0, d} == m - 5'd1) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to digit decoder.
// Optional macro DISPLAY_DP_CHECK_EN rejects codes with the dp segment lit.
module seg7_decode
    import display_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (code[6:0] == SEG_CODE[i][6:0]) begin
                digit = 4'(i);
                valid = 1'b1;
            end
        end
`ifdef DISPLAY_DP_CHECK_EN
        if (!code[7]) begin
            digit = 4'd0;
            valid = 1'b0;
        end
`else
`endif
    end

endmodule

// File: rtl/display_seq_monitor.sv
// Tracks a counting seven-segment display and flags out-of-sequence digits.
// Optional macro DISPLAY_DP_CHECK_EN (in seg7_decode) makes a lit dp invalid.
module display_seq_monitor
    import display_pkg::*;
#(
    parameter int MODULUS    = 10,
    parameter int MISS_LIMIT = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Sample_en,
    input  logic [7:0]          Display_in,
    output logic [3:0]          Digit_out,
    output logic                Digit_valid,
    output logic                Error,
    output logic [7:0]          Err_count,
    output logic                Locked,
    output logic [STATE_W-1:0]  State_out
);

    localparam logic [4:0] MOD  = 5'(MODULUS);
    localparam logic [2:0] MLIM = 3'(MISS_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic [2:0] miss_q, miss_d;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] dec_digit;
    logic       dec_valid;
    logic       sample_ok;
    logic [2:0] miss_inc;

    seg7_decode u_dec (
        .code  (Display_in),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    assign sample_ok = dec_valid && ({1'b0, dec_digit} < MOD);
    assign miss_inc  = miss_q + 3'd1;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        miss_d  = miss_q;
        digit_d = digit_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (Sample_en) begin
            if (sample_ok) begin
                digit_d = dec_digit;
                valid_d = 1'b1;
            end
            unique case (state_q)
                HUNT, RELOCK: begin
                    if (sample_ok) begin
                        state_d = LOCKED;
                        exp_d   = wrap_inc(dec_digit, MOD);
                        miss_d  = 3'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (sample_ok && dec_digit == exp_q) begin
                        exp_d  = wrap_inc(exp_q, MOD);
                        miss_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != 8'hFF)
                            cnt_d = cnt_q + 8'd1;
                        // A single miss is treated as a dropped digit.
                        if (miss_inc >= MLIM) begin
                            state_d = RELOCK;
                            miss_d  = 3'd0;
                        end else begin
                            miss_d = miss_inc;
                            exp_d  = wrap_inc(exp_q, MOD);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= HUNT;
            exp_q   <= 4'd0;
            miss_q  <= 3'd0;
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            miss_q  <= miss_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Digit_out   = digit_q;
    assign Digit_valid = valid_q;
    assign Error       = err_q;
    assign Err_count   = cnt_q;
    assign Locked      = (state_q == LOCKED);
    assign State_out   = state_q;

endmodule

// File: tb/tb_display_seq_monitor.sv
// Directed-vector bench for display_seq_monitor (MODULUS=10, MISS_LIMIT=2).
module tb_display_seq_monitor;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic       Sample_en = 1'b0;
    logic [7:0] Display_in = 8'hFF;
    logic [3:0] Digit_out;
    logic       Digit_valid;
    logic       Error;
    logic [7:0] Err_count;
    logic       Locked;
    logic [1:0] State_out;

    int n_vec = 0;
    int n_bad = 0;

    display_seq_monitor #(
        .MODULUS    (10),
        .MISS_LIMIT (2)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Sample_en   (Sample_en),
        .Display_in  (Display_in),
        .Digit_out   (Digit_out),
        .Digit_valid (Digit_valid),
        .Error       (Error),
        .Err_count   (Err_count),
        .Locked      (Locked),
        .State_out   (State_out)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [7:0] code);
        @(negedge Clock);
        Sample_en  = en;
        Display_in = code;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".digit"}, 32'(Digit_out), 0);
        chk({tag, ".valid"}, 32'(Digit_valid), 0);
        chk({tag, ".err"}, 32'(Error), 0);
        chk({tag, ".cnt"}, 32'(Err_count), 0);
        chk({tag, ".lock"}, 32'(Locked), 0);
        chk({tag, ".state"}, 32'(State_out), 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Sample_en = 1'b0;
        #2 Resetn = 1'b0;
        #1 chk_zero("rst");
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        int errs;
        logic exp_err;

        #3 Resetn = 1'b0;
        #1 chk_zero("por");
        @(negedge Clock);
        Resetn = 1'b1;

        // Clean count 0..3
        step(1, 8'hC0);
        chk("seq0.lock", 32'(Locked), 1);
        chk("seq0.digit", 32'(Digit_out), 0);
        chk("seq0.valid", 32'(Digit_valid), 1);
        step(1, 8'hF9);
        chk("seq1.digit", 32'(Digit_out), 1);
        chk("seq1.err", 32'(Error), 0);
        step(1, 8'hA4);
        chk("seq2.digit", 32'(Digit_out), 2);
        step(1, 8'hB0);
        chk("seq3.digit", 32'(Digit_out), 3);
        chk("seq3.err", 32'(Error), 0);
        chk("seq3.cnt", 32'(Err_count), 0);

        // Sample_en low holds everything
        step(0, 8'h99);
        chk("idle.valid", 32'(Digit_valid), 0);
        chk("idle.digit", 32'(Digit_out), 3);
        chk("idle.lock", 32'(Locked), 1);
        step(1, 8'h99);
        chk("idle.next", 32'(Error), 0);

        // Wrap 8,9,0
        do_reset();
        step(1, 8'h80);
        chk("wrap8.lock", 32'(Locked), 1);
        step(1, 8'h90);
        chk("wrap9.err", 32'(Error), 0);
        step(1, 8'hC0);
        chk("wrap0.err", 32'(Error), 0);
        chk("wrap0.digit", 32'(Digit_out), 0);
        step(1, 8'hF9);
        chk("wrap1.err", 32'(Error), 0);
        chk("wrap.cnt", 32'(Err_count), 0);

        // Two misses drop lock
        do_reset();
        step(1, 8'hB0);
        step(1, 8'h92);
        chk("miss1.err", 32'(Error), 1);
        chk("miss1.state", 32'(State_out), 1);
        step(1, 8'h82);
        chk("miss2.err", 32'(Error), 1);
        chk("miss2.cnt", 32'(Err_count), 2);
        chk("miss2.state", 32'(State_out), 2);
        chk("miss2.lock", 32'(Locked), 0);
        step(1, 8'hFF);
        chk("relock.err", 32'(Error), 0);
        chk("relock.state", 32'(State_out), 0);
        chk("relock.digit", 32'(Digit_out), 6);

        // Dropped digit tolerated
        do_reset();
        step(1, 8'hB0);
        step(1, 8'hFF);
        chk("drop.err", 32'(Error), 1);
        chk("drop.valid", 32'(Digit_valid), 0);
        chk("drop.digit", 32'(Digit_out), 3);
        step(1, 8'h92);
        chk("drop.err2", 32'(Error), 0);
        chk("drop.cnt", 32'(Err_count), 1);
        chk("drop.lock", 32'(Locked), 1);

        // Digit A is beyond MODULUS=10
        do_reset();
        step(1, 8'h88);
        chk("mod.valid", 32'(Digit_valid), 0);
        chk("mod.state", 32'(State_out), 0);

        // dp lit
        do_reset();
        step(1, 8'h40);
`ifdef DISPLAY_DP_CHECK_EN
        chk("dp.valid", 32'(Digit_valid), 0);
        chk("dp.lock", 32'(Locked), 0);
`else
        chk("dp.valid", 32'(Digit_valid), 1);
        chk("dp.digit", 32'(Digit_out), 0);
        chk("dp.lock", 32'(Locked), 1);
`endif

        // Saturation: constant 0 gives lock, miss, miss->relock, ...
        do_reset();
        errs = 0;
        for (int k = 1; k <= 450; k++) begin
            step(1, 8'hC0);
            exp_err = (k >= 2) && (k % 3 != 1);
            if (exp_err) errs++;
            chk("sat.err", 32'(Error), 32'(exp_err));
            chk("sat.cnt", 32'(Err_count), (errs > 255) ? 255 : errs);
        end
        step(1, 8'h99);
        chk("sat.digit", 32'(Digit_out), 4);
        chk("sat.lock", 32'(Locked), 1);

        // Asynchronous reset mid-cycle
        @(negedge Clock);
        Sample_en = 1'b1;
        Display_in = 8'hFF;
        #2 Resetn = 1'b0;
        #1 chk_zero("amid");
        @(posedge Clock);
        #1 chk_zero("hold");
        @(negedge Clock);
        Resetn = 1'b1;
        step(1, 8'hA4);
        chk("post.valid", 32'(Digit_valid), 1);
        chk("post.digit", 32'(Digit_out), 2);
        chk("post.lock", 32'(Locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
